skip_adder_iter: RTL and testbench

SKIP_ADDER_ITER -- requirements
Module: skip_adder_iter

---
 rtl/skip_adder_iter_if.sv | 31 +++
 rtl/skip_adder_iter.sv | 125 ++++++++++++
 tb/tb_skip_adder_iter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/skip_adder_iter_if.sv
// Operand/result bundle for the iterative carry-skip adder.
// The master drives the request; the slave is the adder.
interface skip_adder_iter_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
);
    localparam int unsigned G  = WIDTH / BLOCK;
    localparam int unsigned CW = $clog2(G + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic [CW-1:0]    skip_count;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, s, cout, ovf, skip_count
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, s, cout, ovf, skip_count
    );
endinterface

// File: rtl/skip_adder_iter.sv
// Iterative carry-skip adder/subtractor: one BLOCK-bit group per cycle, G = WIDTH/BLOCK cycles,
// with a count of groups whose propagate was all-ones.
module skip_adder_iter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input logic             clk,
    input logic             rst_n,
    skip_adder_iter_if.slave bus
);
    localparam int unsigned G  = WIDTH / BLOCK;
    localparam int unsigned KW = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned CW = $clog2(G + 1);
    localparam logic [KW-1:0] KLast = KW'(G - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic             c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    skip_q, skip_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [BLOCK-1:0] grp_a, grp_b, grp_sum;
    logic             carry, c_msb, grp_p, grp_c;

    // Group datapath: ripple through the current group, then apply the skip path.
    always_comb begin
        grp_a   = a_q[k_q * BLOCK +: BLOCK];
        grp_b   = bx_q[k_q * BLOCK +: BLOCK];
        grp_sum = '0;
        carry   = c_q;
        c_msb   = c_q;
        for (int i = 0; i < BLOCK; i++) begin
            c_msb      = carry;
            grp_sum[i] = grp_a[i] ^ grp_b[i] ^ carry;
            carry      = (grp_a[i] & grp_b[i]) | (carry & (grp_a[i] ^ grp_b[i]));
        end
        grp_p = &(grp_a ^ grp_b);
        grp_c = carry | (grp_p & c_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bx_d    = bx_q;
        c_d     = c_q;
        k_d     = k_q;
        acc_d   = acc_q;
        skip_d  = skip_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_d     = bus.a;
                    bx_d    = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub | bus.cin;
                    k_d     = '0;
                    skip_d  = '0;
                    acc_d   = '0;
                end
            end
            StRun: begin
                acc_d[k_q * BLOCK +: BLOCK] = grp_sum;
                c_d    = grp_c;
                k_d    = k_q + 1'b1;
                skip_d = skip_q + CW'(grp_p);
                if (k_q == KLast) begin
                    state_d = StDone;
                    s_d     = acc_d;
                    cout_d  = grp_c;
                    ovf_d   = c_msb ^ grp_c;
                    cnt_d   = skip_d;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            bx_q    <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            acc_q   <= '0;
            skip_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            c_q     <= c_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            skip_q  <= skip_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy       = (state_q == StRun);
    assign bus.done       = (state_q == StDone);
    assign bus.s          = s_q;
    assign bus.cout       = cout_q;
    assign bus.ovf        = ovf_q;
    assign bus.skip_count = cnt_q;
endmodule

// File: tb/tb_skip_adder_iter.sv
// Self-checking bench for skip_adder_iter (WIDTH=16, BLOCK=4): directed table, multi-cycle
// corner sequences and randomized operations against an arithmetic reference model.
module tb_skip_adder_iter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    skip_adder_iter_if #(.WIDTH(16), .BLOCK(4)) bus ();

    skip_adder_iter #(.WIDTH(16), .BLOCK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic [2:0]  skip;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: full-width add, sign rule for overflow, nibble scan for skips.
    task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                             input logic sub, output logic [15:0] s, output logic cout,
                             output logic ovf, output logic [2:0] sk);
        logic [15:0] bx;
        logic [16:0] full;
        bx   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + 17'(sub ? 1'b1 : cin);
        s    = full[15:0];
        cout = full[16];
        ovf  = (a[15] == bx[15]) && (s[15] != a[15]);
        sk   = 3'd0;
        for (int g = 0; g < 4; g++)
            if ((((a ^ bx) >> (4 * g)) & 16'hF) == 16'hF) sk = sk + 3'd1;
    endtask

    // Caller must be in IDLE, away from a rising edge; the request is accepted on the next one.
    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo, input logic [2:0] ek);
        logic [15:0] s_prev;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        s_prev    = bus.s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.cin   = 1'($urandom);
        bus.sub   = 1'($urandom);
        for (int i = 0; i < 4; i++) begin
            check({name, "/run"}, {bus.busy, bus.done, bus.s}, {1'b1, 1'b0, s_prev});
            @(posedge clk);
            #1;
        end
        check({name, "/done"}, {bus.busy, bus.done}, 2'b01);
        check({name, "/result"}, {bus.s, bus.cout, bus.ovf, bus.skip_count}, {es, ec, eo, ek});
        @(posedge clk);
        #1;
        check({name, "/hold"}, {bus.busy, bus.done, bus.s, bus.cout, bus.ovf, bus.skip_count},
              {2'b00, es, ec, eo, ek});
    endtask

    initial begin
        logic [15:0] ra, rb, es;
        logic        rc, rs, ec, eo;
        logic [2:0]  ek;
        int          n, dones;

        checks    = 0;
        failures  = 0;
        vecs[0]   = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 3'd1};
        vecs[1]   = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd4};
        vecs[2]   = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 3'd2};
        vecs[3]   = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 3'd3};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        #1;
        check("reset", {bus.busy, bus.done, bus.s, bus.cout, bus.ovf, bus.skip_count}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First vector goes in on the very first rising edge after reset release.
        for (int i = 0; i < 4; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                  vecs[i].s, vecs[i].cout, vecs[i].ovf, vecs[i].skip);

        // Start held through RUN with a new operand: only the first request executes.
        ref_model(16'h1234, 16'h1111, 1'b0, 1'b0, es, ec, eo, ek);
        bus.a     = 16'h1234;
        bus.b     = 16'h1111;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            check("hold_start/run", {bus.busy, bus.done}, 2'b10);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        check("hold_start/done", bus.done, 1'b1);
        check("hold_start/result", {bus.s, bus.cout, bus.ovf, bus.skip_count},
              {16'h2345, ec, eo, ek});
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("hold_start/extra_done", dones, 0);

        // Continuous start: back-to-back operations every G+2 cycles.
        bus.start = 1'b1;
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tput/first_latency", n, 5);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 20);
        check("tput/period", n, 6);
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the second RUN cycle discards the operation.
        bus.a     = 16'hABCD;
        bus.b     = 16'h1357;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset", {bus.busy, bus.done, bus.s, bus.cout, bus.ovf, bus.skip_count},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        check("midrun_reset/no_done", dones, 0);
        do_op("after_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 3'd0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (i % 8 == 0) rb = ~ra;
            ref_model(ra, rb, rc, rs, es, ec, eo, ek);
            do_op($sformatf("rand%0d", i), ra, rb, rc, rs, es, ec, eo, ek);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
